// File: rtl/cpc_rom_loader_pkg.sv
`default_nettype none
// ============================================================================
// cpc_loader_pkg : page constants, boot-write queue entry, hex-digit decoder
// Revision: 1.0
// ============================================================================
package cpc_loader_pkg;

  localparam logic [8:0] PAGE_LOW0   = 9'h000;
  localparam logic [8:0] PAGE_UP0    = 9'h100;
  localparam logic [8:0] PAGE_AMSDOS = 9'h107;
  localparam logic [8:0] PAGE_MF2    = 9'h1FF;
  localparam logic [8:0] PAGE_BAD    = 9'h1EE;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  bank;
    logic [7:0]  d;
  } boot_entry_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] val;
  } hex_digit_t;

  // Upper-case ASCII hex digit; anything else is reported invalid.
  function automatic hex_digit_t hex_decode(input logic [7:0] c);
    hex_digit_t r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r.valid = 1'b1;
      r.val   = c[3:0];
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r.valid = 1'b1;
      r.val   = c[3:0] + 4'd9;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpc_rom_loader_if.sv
`default_nettype none
// ============================================================================
// cpc_rom_loader_if : ioctl download, SDRAM boot-write and ROM-map signals
// Revision: 1.0
// ============================================================================
interface cpc_rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic [15:0] ioctl_file_ext;
  logic        model;
  logic        mem_ce;
  logic        boot_wr;
  logic [22:0] boot_a;
  logic [1:0]  boot_bank;
  logic [7:0]  boot_dout;
  logic [7:0]  map_addr;
  logic        map_hit;
  logic        busy;
  logic        ovf;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
           ioctl_file_ext, model, mem_ce, map_addr,
    input  boot_wr, boot_a, boot_bank, boot_dout, map_hit, busy, ovf
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
           ioctl_file_ext, model, mem_ce, map_addr,
    output boot_wr, boot_a, boot_bank, boot_dout, map_hit, busy, ovf
  );
endinterface
`default_nettype wire

// File: rtl/cpc_rom_loader_fifo.sv
`default_nettype none
// ============================================================================
// loader_fifo : power-of-two skid FIFO of boot-write entries, head held stable
// Revision: 1.0
// ============================================================================
module loader_fifo
  import cpc_loader_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        push_i,
  input  boot_entry_t din_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output boot_entry_t head_o
);
  localparam int AW = $clog2(DEPTH);

  boot_entry_t  mem_q [DEPTH];
  logic [AW:0]  wp_q;
  logic [AW:0]  rp_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head_o  = mem_q[rp_q[AW-1:0]];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q[AW-1:0]] <= din_i;
        wp_q                <= wp_q + 1'b1;
      end
      if (do_pop) rp_q <= rp_q + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/cpc_rom_loader.sv
`default_nettype none
// ============================================================================
// cpc_rom_loader : maps ioctl ROM bytes to SDRAM pages, queues boot writes,
// keeps the expansion-ROM present map. Option macro: CPC_COMBO_ROM_EN.
// Revision: 1.0
// ============================================================================
module cpc_rom_loader
  import cpc_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk_sys,
  input  logic             reset,
  cpc_rom_loader_if.slave  bus
);
  logic         dl_q;
  logic         wr_q;
  logic [8:0]   page_q;
  logic         ovf_q;
  logic [255:0] map_q;
  logic         map_hit_q;
`ifdef CPC_COMBO_ROM_EN
  logic         combo_q;
  logic         ext_combo;
`endif

  hex_digit_t   ext_hi;
  hex_digit_t   ext_lo;
  logic [8:0]   ext_page;
  logic [10:0]  blk;
  logic [8:0]   sys_page;
  logic [7:0]   exp_blk;
  boot_entry_t  ent;
  logic         map_ok;
  logic         dl_rise;
  logic         capture;
  logic         full;
  logic         empty;
  logic         pop;
  logic         accept;
  logic         drop;
  boot_entry_t  head;

  assign dl_rise = bus.ioctl_download & ~dl_q;
  assign capture = bus.ioctl_wr & ~wr_q & bus.ioctl_download & map_ok;
  assign pop     = bus.mem_ce & ~empty;
  assign accept  = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  // Page chosen at download start. Any valid hex digit selects the lower
  // half (page[8]=0); two invalid characters leave the parking page.
  always_comb begin
    ext_hi   = hex_decode(bus.ioctl_file_ext[15:8]);
    ext_lo   = hex_decode(bus.ioctl_file_ext[7:0]);
    ext_page = PAGE_BAD;
`ifdef CPC_COMBO_ROM_EN
    ext_combo = 1'b0;
`endif
    if (bus.ioctl_file_ext == 16'h5A5A) begin
      ext_page = PAGE_LOW0;
    end else if (bus.ioctl_file_ext == 16'h5A30) begin
      ext_page = PAGE_LOW0;
`ifdef CPC_COMBO_ROM_EN
      ext_combo = 1'b1;
`endif
    end else begin
      if (ext_hi.valid | ext_lo.valid) ext_page[8] = 1'b0;
      if (ext_hi.valid) ext_page[7:4] = ext_hi.val;
      if (ext_lo.valid) ext_page[3:0] = ext_lo.val;
    end
  end

  always_comb begin
    blk = bus.ioctl_addr[24:14];
    case (blk[1:0])
      2'd0:    sys_page = PAGE_LOW0;
      2'd1:    sys_page = PAGE_UP0;
      2'd2:    sys_page = PAGE_AMSDOS;
      default: sys_page = PAGE_MF2;
    endcase
    exp_blk = page_q[7:0] + bus.ioctl_addr[21:14];
    ent.d   = bus.ioctl_dout;
    if (bus.ioctl_index != 8'd0) begin
      ent.a    = {page_q[8], exp_blk, bus.ioctl_addr[13:0]};
      ent.bank = {1'b0, bus.model};
      map_ok   = 1'b1;
    end else begin
      ent.a    = {sys_page, bus.ioctl_addr[13:0]};
      ent.bank = {1'b0, blk[2]};
      map_ok   = (blk[10:3] == 8'd0);
    end
  end

  loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push_i  (capture),
    .din_i   (ent),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  // Edge detectors reload from the pins in reset so that a download already
  // under way is not mistaken for a fresh start when reset releases.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q      <= bus.ioctl_download;
      wr_q      <= bus.ioctl_wr;
      page_q    <= PAGE_LOW0;
      ovf_q     <= 1'b0;
      map_q     <= '0;
      map_hit_q <= 1'b0;
`ifdef CPC_COMBO_ROM_EN
      combo_q   <= 1'b0;
`endif
    end else begin
      dl_q      <= bus.ioctl_download;
      wr_q      <= bus.ioctl_wr;
      map_hit_q <= map_q[bus.map_addr];
      if (dl_rise) begin
        page_q  <= ext_page;
        ovf_q   <= 1'b0;
`ifdef CPC_COMBO_ROM_EN
        combo_q <= ext_combo;
`endif
      end
      if (accept && ent.a[22]) map_q[ent.a[21:14]] <= 1'b1;
      if (drop) ovf_q <= 1'b1;
`ifdef CPC_COMBO_ROM_EN
      // Last byte of the first 16K switches the rest onto the MF2 page.
      if (accept && combo_q && bus.ioctl_addr[13:0] == 14'h3FFF) begin
        page_q  <= PAGE_MF2;
        combo_q <= 1'b0;
      end
`endif
    end
  end

  assign bus.boot_wr   = ~empty;
  assign bus.boot_a    = head.a;
  assign bus.boot_bank = head.bank;
  assign bus.boot_dout = head.d;
  assign bus.map_hit   = map_hit_q;
  assign bus.busy      = bus.ioctl_download | ~empty;
  assign bus.ovf       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_cpc_rom_loader.sv
`default_nettype none
// ============================================================================
// tb_cpc_rom_loader : scoreboard bench for the ROM loader
// Revision: 1.0
// ============================================================================
module tb_cpc_rom_loader;
  import cpc_loader_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  int          n_cmp   = 0;
  int          n_fail  = 0;
  int          ce_period = 0;
  int          ce_cnt  = 0;
  boot_entry_t exp_q[$];

  cpc_rom_loader_if bus();

  cpc_rom_loader #(.FIFO_DEPTH(2)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    #1;
    ce_cnt++;
    if (ce_period != 0) bus.mem_ce = ((ce_cnt % ce_period) == 0);
  end

  // Every SDRAM write taken on the next edge is checked against the queue head.
  always @(negedge clk_sys) begin
    boot_entry_t got;
    boot_entry_t e;
    if (!reset && bus.mem_ce && bus.boot_wr) begin
      got.a = bus.boot_a; got.bank = bus.boot_bank; got.d = bus.boot_dout;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sdram_write unexpected a=%h bank=%0d d=%h", got.a, got.bank, got.d);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL sdram_write got a=%h bank=%0d d=%h expected a=%h bank=%0d d=%h",
                   got.a, got.bank, got.d, e.a, e.bank, e.d);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
  endtask

  task automatic start_dl(input logic [7:0] idx, input logic [15:0] ext);
    bus.ioctl_download = 1'b0;
    tick();
    bus.ioctl_index    = idx;
    bus.ioctl_file_ext = ext;
    bus.ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] d);
    bus.ioctl_addr = addr;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b0;
    tick(3);
  endtask

  task automatic expect_byte(input logic [22:0] a, input logic [1:0] bank, input logic [7:0] d);
    boot_entry_t e;
    e.a = a; e.bank = bank; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.boot_wr   !== 1'b0)  begin n_fail++; $display("FAIL reset_boot_wr got %b want 0", bus.boot_wr); end
    n_cmp++; if (bus.boot_a    !== 23'd0) begin n_fail++; $display("FAIL reset_boot_a got %h want 0", bus.boot_a); end
    n_cmp++; if (bus.boot_bank !== 2'd0)  begin n_fail++; $display("FAIL reset_boot_bank got %0d want 0", bus.boot_bank); end
    n_cmp++; if (bus.boot_dout !== 8'd0)  begin n_fail++; $display("FAIL reset_boot_dout got %h want 0", bus.boot_dout); end
    n_cmp++; if (bus.map_hit   !== 1'b0)  begin n_fail++; $display("FAIL reset_map_hit got %b want 0", bus.map_hit); end
    n_cmp++; if (bus.busy      !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.ovf       !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
  endtask

  task automatic test_sys_rom();
    logic [8:0]  pages [4];
    logic [13:0] offs  [3];
    logic [7:0]  ma    [4];
    logic        mh    [4];
    logic [7:0]  d;
    bit          ok;
    pages = '{9'h000, 9'h100, 9'h107, 9'h1FF};
    offs  = '{14'h0000, 14'h1FFF, 14'h3FFF};
    ma    = '{8'h00, 8'h07, 8'hFF, 8'h05};
    mh    = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    bus.model = 1'b0;
    ce_period = 3;
    start_dl(8'd0, "RO");
    for (int b = 0; b <= 8; b++) begin
      for (int k = 0; k < 3; k++) begin
        d = 8'(b * 16 + k);
        if (b < 8) expect_byte({pages[b % 4], offs[k]}, (b >= 4) ? 2'd1 : 2'd0, d);
        send_byte({11'(b), offs[k]}, d);
      end
    end
    bus.ioctl_download = 1'b0;
    drain(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL sys_drain pending=%0d want 0", exp_q.size()); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL sys_ovf got %b want 0", bus.ovf); end
    for (int i = 0; i < 4; i++) begin
      bus.map_addr = ma[i];
      tick(2);
      n_cmp++;
      if (bus.map_hit !== mh[i]) begin
        n_fail++; $display("FAIL sys_map[%h] got %b want %b", ma[i], bus.map_hit, mh[i]);
      end
    end
  endtask

  task automatic test_exp_rom();
    logic [7:0] ma [4];
    logic       mh [4];
    bit         ok;
    ma = '{8'h07, 8'hA7, 8'hEE, 8'h00};
    mh = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    bus.model = 1'b1;
    ce_period = 3;
    start_dl(8'd1, "07");
    expect_byte(23'h01C000, 2'd1, 8'h11); send_byte(25'h0000000, 8'h11);
    expect_byte(23'h01FFFF, 2'd1, 8'h12); send_byte(25'h0003FFF, 8'h12);
    expect_byte(23'h020000, 2'd1, 8'h13); send_byte(25'h0004000, 8'h13);
    start_dl(8'd1, "A7");
    expect_byte(23'h29C123, 2'd1, 8'h21); send_byte(25'h0000123, 8'h21);
    start_dl(8'd1, "x?");
    expect_byte(23'h7B8042, 2'd1, 8'h31); send_byte(25'h0000042, 8'h31);
    expect_byte(23'h400005, 2'd1, 8'h32); send_byte(25'h0048005, 8'h32);
    bus.ioctl_download = 1'b0;
    drain(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL exp_drain pending=%0d want 0", exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      bus.map_addr = ma[i];
      tick(2);
      n_cmp++;
      if (bus.map_hit !== mh[i]) begin
        n_fail++; $display("FAIL exp_map[%h] got %b want %b", ma[i], bus.map_hit, mh[i]);
      end
    end
  endtask

  task automatic test_combo();
    bit   ok;
    logic want_map0;
    do_reset();
    bus.model = 1'b0;
    ce_period = 3;
    start_dl(8'd1, "Z0");
    expect_byte(23'h000000, 2'd0, 8'h41); send_byte(25'h0000000, 8'h41);
    expect_byte(23'h003FFF, 2'd0, 8'h42); send_byte(25'h0003FFF, 8'h42);
`ifdef CPC_COMBO_ROM_EN
    expect_byte(23'h400000, 2'd0, 8'h43);
    expect_byte(23'h400001, 2'd0, 8'h44);
    want_map0 = 1'b1;
`else
    expect_byte(23'h004000, 2'd0, 8'h43);
    expect_byte(23'h004001, 2'd0, 8'h44);
    want_map0 = 1'b0;
`endif
    send_byte(25'h0004000, 8'h43);
    send_byte(25'h0004001, 8'h44);
    bus.ioctl_download = 1'b0;
    drain(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL combo_drain pending=%0d want 0", exp_q.size()); end
    bus.map_addr = 8'h00;
    tick(2);
    n_cmp++; if (bus.map_hit !== want_map0) begin n_fail++; $display("FAIL combo_map0 got %b want %b", bus.map_hit, want_map0); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    ce_period  = 0;
    bus.mem_ce = 1'b0;
    bus.model  = 1'b0;
    start_dl(8'd1, "07");
    expect_byte(23'h01C001, 2'd0, 8'h51); send_byte(25'h0000001, 8'h51);
    expect_byte(23'h01C002, 2'd0, 8'h52); send_byte(25'h0000002, 8'h52);
    send_byte(25'h0000003, 8'h53);
    n_cmp++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", bus.ovf); end
    n_cmp++; if (bus.boot_wr !== 1'b1) begin n_fail++; $display("FAIL ovf_boot_wr got %b want 1", bus.boot_wr); end
    n_cmp++; if (bus.boot_a !== 23'h01C001) begin n_fail++; $display("FAIL ovf_head got %h want 01c001", bus.boot_a); end
    bus.ioctl_download = 1'b0;
    ce_period = 3;
    drain(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL ovf_drain pending=%0d want 0", exp_q.size()); end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", bus.ovf); end
    ce_period  = 0;
    bus.mem_ce = 1'b0;
    start_dl(8'd1, "07");
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", bus.ovf); end
    bus.ioctl_download = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    ce_period  = 0;
    bus.mem_ce = 1'b0;
    bus.model  = 1'b1;
    start_dl(8'd1, "07");
    expect_byte(23'h01C010, 2'd1, 8'h61); send_byte(25'h0000010, 8'h61);
    expect_byte(23'h01C011, 2'd1, 8'h62); send_byte(25'h0000011, 8'h62);
    expect_byte(23'h01C012, 2'd1, 8'h63);
    bus.ioctl_addr = 25'h0000012;
    bus.ioctl_dout = 8'h63;
    bus.ioctl_wr   = 1'b1;
    bus.mem_ce     = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b0;
    bus.mem_ce     = 1'b0;
    tick(3);
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf got %b want 0", bus.ovf); end
    n_cmp++; if (bus.boot_a !== 23'h01C011) begin n_fail++; $display("FAIL b2b_head got %h want 01c011", bus.boot_a); end
    bus.ioctl_download = 1'b0;
    ce_period = 3;
    drain(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_drain pending=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    ce_period  = 0;
    bus.mem_ce = 1'b0;
    bus.model  = 1'b0;
    start_dl(8'd0, "RO");
    send_byte(25'h0008010, 8'h71);
    send_byte(25'h0008011, 8'h72);
    bus.map_addr = 8'h07;
    tick(2);
    n_cmp++; if (bus.map_hit !== 1'b1) begin n_fail++; $display("FAIL mid_map_before got %b want 1", bus.map_hit); end
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.boot_wr !== 1'b0) begin n_fail++; $display("FAIL mid_boot_wr got %b want 0", bus.boot_wr); end
    reset = 1'b0;
    exp_q.delete();
    tick(2);
    n_cmp++; if (bus.map_hit !== 1'b0) begin n_fail++; $display("FAIL mid_map_after got %b want 0", bus.map_hit); end
    bus.ioctl_index = 8'd1;
    expect_byte(23'h004005, 2'd0, 8'h73); send_byte(25'h0004005, 8'h73);
    bus.ioctl_download = 1'b0;
    ce_period = 3;
    drain(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL mid_drain pending=%0d want 0", exp_q.size()); end
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_index    = '0;
    bus.ioctl_file_ext = '0;
    bus.model          = 1'b0;
    bus.mem_ce         = 1'b0;
    bus.map_addr       = '0;
    test_reset();
    test_sys_rom();
    test_exp_rom();
    test_combo();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover_expected count=%0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
